maxpool2d_stream: RTL

- Parametrised successor to the single-window binary max-pool stage.
- Captures IC binary feature maps with one valid/ready handshake, then pools LANES channels per cycle through a configurable K×K window with stride S.
- Presents all pooled maps with an out_valid/out_ready handshake.
- Sits between a binary conv stage and the next conv/FC stage of the BNN pipeline; supports max (OR) or min (AND) pooling selected per frame.

---
 rtl/maxpool2d_stream.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/maxpool2d_stream.sv
// Streaming binary 2-D max/min pool: buffers one IC-channel frame, then pools LANES channels per cycle.
// Define MAXPOOL2D_CEIL_PAD_EN for ceil-mode output sizing with partial edge windows.
module maxpool2d_stream #(
  parameter int unsigned IMG_IN_SIZE = 28,
  parameter int unsigned IC          = 10,
  parameter int unsigned POOL_K      = 2,
  parameter int unsigned STRIDE      = 2,
  parameter int unsigned LANES       = 2,
`ifdef MAXPOOL2D_CEIL_PAD_EN
  localparam int unsigned IMG_OUT_SIZE =
      (IMG_IN_SIZE - POOL_K + STRIDE - 1) / ((STRIDE == 0) ? 1 : STRIDE) + 1
`else
  localparam int unsigned IMG_OUT_SIZE =
      (IMG_IN_SIZE - POOL_K) / ((STRIDE == 0) ? 1 : STRIDE) + 1
`endif
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic                                 mode,
  input  logic [IMG_IN_SIZE*IMG_IN_SIZE-1:0]   img_in [IC],
  output logic [IMG_OUT_SIZE*IMG_OUT_SIZE-1:0] img_out [IC],
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 busy
);

  localparam int unsigned InBits  = IMG_IN_SIZE * IMG_IN_SIZE;
  localparam int unsigned OutBits = IMG_OUT_SIZE * IMG_OUT_SIZE;
  localparam int unsigned G       = (IC + LANES - 1) / ((LANES == 0) ? 1 : LANES);
  localparam int unsigned GW      = (G > 1) ? $clog2(G) : 1;

  if (POOL_K > IMG_IN_SIZE || STRIDE == 0 || LANES == 0 || LANES > IC) begin : g_param_check
    $error("maxpool2d_stream: illegal POOL_K/STRIDE/LANES parameters");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e              state_q, state_d;
  logic [InBits-1:0]   buf_q [IC];
  logic [InBits-1:0]   buf_d [IC];
  logic                mode_q, mode_d;
  logic [GW-1:0]       g_q, g_d;
  logic [OutBits-1:0]  img_out_q [IC];
  logic [OutBits-1:0]  img_out_d [IC];
  logic [InBits-1:0]   lane_map [LANES];
  logic [OutBits-1:0]  pooled [LANES];

  // Out-of-bounds window cells are skipped, which equals padding with the
  // identity of the reduction (0 for OR, 1 for AND).
  function automatic logic [OutBits-1:0] pool_map(input logic [InBits-1:0] m, input logic mn);
    logic [OutBits-1:0] res;
    logic [InBits-1:0]  sh;
    logic               acc;
    int unsigned        rr, cc;
    res = '0;
    for (int unsigned i = 0; i < IMG_OUT_SIZE; i++) begin
      for (int unsigned j = 0; j < IMG_OUT_SIZE; j++) begin
        acc = mn;
        for (int unsigned r = 0; r < POOL_K; r++) begin
          for (int unsigned c = 0; c < POOL_K; c++) begin
            rr = i * STRIDE + r;
            cc = j * STRIDE + c;
            if (rr < IMG_IN_SIZE && cc < IMG_IN_SIZE) begin
              sh  = m >> (rr * IMG_IN_SIZE + cc);
              acc = mn ? (acc & sh[0]) : (acc | sh[0]);
            end
          end
        end
        res = res | (OutBits'(acc) << (i * IMG_OUT_SIZE + j));
      end
    end
    return res;
  endfunction

  // Lanes past the last channel select nothing and are never written back.
  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_map[l] = '0;
      for (int unsigned c = 0; c < IC; c++) begin
        if (c == 32'(g_q) * LANES + l) lane_map[l] = buf_q[c];
      end
      pooled[l] = pool_map(lane_map[l], mode_q);
    end
  end

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    mode_d    = mode_q;
    g_d       = g_q;
    img_out_d = img_out_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          buf_d   = img_in;
          mode_d  = mode;
          g_d     = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        busy = 1'b1;
        for (int unsigned c = 0; c < IC; c++) begin
          if (c / LANES == 32'(g_q)) img_out_d[c] = pooled[c % LANES];
        end
        if (g_q == GW'(G - 1)) begin
          state_d = StDone;
        end else begin
          g_d = g_q + GW'(1);
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mode_q  <= 1'b0;
      g_q     <= '0;
      for (int unsigned c = 0; c < IC; c++) begin
        buf_q[c]     <= '0;
        img_out_q[c] <= '0;
      end
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      g_q       <= g_d;
      buf_q     <= buf_d;
      img_out_q <= img_out_d;
    end
  end

  assign img_out = img_out_q;

endmodule
